pipe_ifid_reg: RTL
==================

# pipe_ifid_reg

IF/ID pipeline register of the five-stage pipelined CPU: captures the fetch stage's instruction word, PC and PC+4 on each clock edge and presents them to the decode stage. It supports a load-use stall that holds the register and a control-hazard flush that inserts a bubble. It also keeps saturating performance counters for fetches accepted, stall cycles and flushes, readable through the IO extension.

## Interface
Parameters:
- WIDTH, 32, width of the instruction and address paths
- CNT_W, 16, width of each performance counter

Ports:
- clock  in  1  pipeline clock, all state updates on rising edge
- resetn  in  1  asynchronous active-low reset
- pc  in  WIDTH  address of the instruction currently being fetched
- pc4  in  WIDTH  pc + 4 from the fetch stage
- ins  in  WIDTH  instruction word from the fetch stage (already 0 when fetch squashes it)
- wpcir  in  1  write enable: 1 = capture, 0 = hold (load-use stall)
- flush  in  1  1 = replace the incoming instruction with a bubble
- cnt_clr  in  1  synchronous clear of all three counters
- dpc  out  WIDTH  registered pc for decode
- dpc4  out  WIDTH  registered pc4 for decode
- inst  out  WIDTH  registered instruction for decode
- dvalid  out  1  1 = inst is a real fetched instruction, 0 = bubble
- cnt_fetch  out  CNT_W  cycles in which a valid instruction was accepted
- cnt_stall  out  CNT_W  cycles held by wpcir = 0
- cnt_flush  out  CNT_W  cycles in which a bubble was inserted by flush

## Operation
- Reset (resetn = 0, asynchronous): dpc, dpc4, inst and all counters are 0, and dvalid is 0. The register holds these values while resetn is low, regardless of clock.
- At each rising edge with resetn = 1, exactly one case applies, in priority order:
  - wpcir = 0 (hold): dpc, dpc4, inst and dvalid keep their values. flush is ignored in this case. cnt_stall increments.
  - wpcir = 1, flush = 1 (bubble): inst is 0, dvalid is 0, and dpc and dpc4 take pc and pc4, which are kept for debug. cnt_flush increments.
  - wpcir = 1, flush = 0 (accept): dpc, dpc4 and inst take pc, pc4 and ins, and dvalid is 1. cnt_fetch increments. An ins value of 0 is still counted and marked valid, because it is a real sll nop.
- Counters:
  - Each counter saturates at all-ones and does not wrap.
  - cnt_clr = 1 sets all three counters to 0 at the edge. The clear takes priority over increments, so an event in the same cycle is not counted.
  - cnt_clr does not affect the datapath registers.
- There is no combinational path from any input to any output.

## Timing
- Latency is 1 cycle: values present at the edge appear on the outputs immediately after that edge.
- A stall of N consecutive cycles holds the outputs for N cycles and adds N to cnt_stall. The instruction presented on the first cycle after wpcir returns to 1 is captured on that edge.
- Flush is a single-cycle bubble per asserted cycle. Back-to-back flush cycles each insert one bubble and each count once.
- If resetn is asserted while stalled or mid-flush, all outputs go to their reset values immediately. The first edge after resetn rises behaves as a normal accept, bubble or hold according to wpcir and flush.
- Counter outputs are registered and reflect events up to and including the last edge.

## Test plan
- Reset then accept: hold resetn = 0, check all outputs are 0. Release, then apply pc = 0x0, pc4 = 0x4, ins = 0x3c010000 with wpcir = 1 and flush = 0. After the edge: dpc = 0, dpc4 = 4, inst = 0x3c010000, dvalid = 1, cnt_fetch = 1.
- Stall: after an accept of ins = 0x8c220004, hold wpcir = 0 for 3 cycles while ins changes to 0x00430820. inst stays 0x8c220004 for 3 cycles and cnt_stall = 3. On the next edge with wpcir = 1, inst = 0x00430820.
- Flush: with wpcir = 1, flush = 1, pc = 0x10, ins = 0x1000ffff. After the edge: inst = 0, dvalid = 0, dpc = 0x10, cnt_flush = 1, cnt_fetch unchanged.
- Stall plus flush in the same cycle: apply wpcir = 0 and flush = 1 together. Outputs are held, cnt_stall increments by 1, and cnt_flush is unchanged.
- Saturation and clear:
  - Force 65537 accept cycles: cnt_fetch = 0xffff and does not wrap.
  - Pulse cnt_clr together with an accept: all counters = 0 while inst still updates.
- Asynchronous reset mid-stall: drop resetn between clock edges during a stall. Outputs go to 0 before the next edge.

Source files
------------

// File: rtl/pipe_ifid_reg.sv
// rtl/pipe_ifid_reg.sv - IF/ID pipeline register with stall, flush and saturating performance counters
module pipe_ifid_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc4,
  input  logic [WIDTH-1:0] ins,
  input  logic             wpcir,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] dpc,
  output logic [WIDTH-1:0] dpc4,
  output logic [WIDTH-1:0] inst,
  output logic             dvalid,
  output logic [CNT_W-1:0] cnt_fetch,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  // Cycle classification shared by the datapath and the counters; the hold
  // case wins over flush so a stalled instruction is never squashed.
  logic ev_stall;
  logic ev_flush;
  logic ev_fetch;

  assign ev_stall = ~wpcir;
  assign ev_flush = wpcir & flush;
  assign ev_fetch = wpcir & ~flush;

  // Pipeline register: hold on stall, bubble on flush (pc kept for debug), else capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dpc    <= '0;
      dpc4   <= '0;
      inst   <= '0;
      dvalid <= 1'b0;
    end else if (ev_flush) begin
      dpc    <= pc;
      dpc4   <= pc4;
      inst   <= '0;
      dvalid <= 1'b0;
    end else if (ev_fetch) begin
      dpc    <= pc;
      dpc4   <= pc4;
      inst   <= ins;
      dvalid <= 1'b1;
    end
  end

  // Performance counters: clear beats increment, each saturates at all-ones.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_fetch <= '0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else if (cnt_clr) begin
      cnt_fetch <= '0;
      cnt_stall <= '0;
      cnt_flush <= '0;
    end else begin
      if (ev_fetch && (cnt_fetch != {CNT_W{1'b1}}))
        cnt_fetch <= cnt_fetch + CNT_W'(1);
      if (ev_stall && (cnt_stall != {CNT_W{1'b1}}))
        cnt_stall <= cnt_stall + CNT_W'(1);
      if (ev_flush && (cnt_flush != {CNT_W{1'b1}}))
        cnt_flush <= cnt_flush + CNT_W'(1);
    end
  end

endmodule
